// File: rtl/m1_trace_buffer.sv
// m1_trace_buffer: captures {pc, probe} at every M1/T0 strobe into a circular buffer.
// Optional breakpoint stop is compiled in with `define M1_TRACE_BREAK_EN.
module m1_trace_buffer #(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 16,
    parameter int PROBE_W = 64,
    parameter int CNT_W   = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m1_strobe,
    input  logic [ADDR_W-1:0]         pc,
    input  logic [PROBE_W-1:0]        probe,
    input  logic                      arm,
    input  logic                      mode,
    input  logic [CNT_W-1:0]          stop_limit,
`ifdef M1_TRACE_BREAK_EN
    input  logic                      bp_en,
    input  logic [ADDR_W-1:0]         bp_addr,
    output logic                      bp_hit,
`endif
    input  logic                      rd_en,
    input  logic [AW-1:0]             rd_idx,
    output logic [ADDR_W+PROBE_W-1:0] rd_data,
    output logic                      rd_valid,
    output logic [AW:0]               level,
    output logic [CNT_W-1:0]          step_count,
    output logic                      running,
    output logic                      done,
    output logic                      wrapped
);

    localparam int EW = ADDR_W + PROBE_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [AW:0]      FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]      LVL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             wrapped_q, wrapped_d;
    logic             wr_en;
    logic             stop;
`ifdef M1_TRACE_BREAK_EN
    logic             bp_hit_q, bp_hit_d;
`endif

    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    rd_data_q;
    logic             rd_valid_q;
    logic [AW-1:0]    rd_phys;

    // Next-state: arm restarts capture, a strobe in RUN stores one entry
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        level_d   = level_q;
        step_d    = step_q;
        limit_d   = limit_q;
        mode_d    = mode_q;
        wrapped_d = wrapped_q;
        wr_en     = 1'b0;
        stop      = 1'b0;
`ifdef M1_TRACE_BREAK_EN
        bp_hit_d  = bp_hit_q;
`endif
        if (arm) begin
            state_d   = S_RUN;
            wr_ptr_d  = '0;
            level_d   = '0;
            step_d    = '0;
            wrapped_d = 1'b0;
            mode_d    = mode;
            limit_d   = stop_limit;
`ifdef M1_TRACE_BREAK_EN
            bp_hit_d  = 1'b0;
`endif
        end else if (state_q == S_RUN && m1_strobe) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (step_q != '1) begin
                step_d = step_q + CNT_ONE;
            end
            if (level_q == FULL) begin
                if (mode_q) begin
                    wrapped_d = 1'b1;
                end
            end else begin
                level_d = level_q + LVL_ONE;
            end
            stop = (limit_q != '0 && step_d == limit_q) ||
                   (!mode_q && level_d == FULL);
`ifdef M1_TRACE_BREAK_EN
            if (bp_en && pc == bp_addr) begin
                bp_hit_d = 1'b1;
                stop     = 1'b1;
            end
`endif
            if (stop) begin
                state_d = S_DONE;
            end
        end
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            level_q   <= '0;
            step_q    <= '0;
            limit_q   <= '0;
            mode_q    <= 1'b0;
            wrapped_q <= 1'b0;
`ifdef M1_TRACE_BREAK_EN
            bp_hit_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            step_q    <= step_d;
            limit_q   <= limit_d;
            mode_q    <= mode_d;
            wrapped_q <= wrapped_d;
`ifdef M1_TRACE_BREAK_EN
            bp_hit_q  <= bp_hit_d;
`endif
        end
    end

    // Trace storage; contents survive reset, a reset edge blocks the write
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[wr_ptr_q] <= {pc, probe};
        end
    end

    // Logical index 0 is the oldest entry, which sits at wr_ptr once wrapped
    always_comb begin
        rd_phys = wrapped_q ? (wr_ptr_q + rd_idx) : rd_idx;
    end

    // Registered readback using pre-capture pointer and contents
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= ({1'b0, rd_idx} < level_q) ? mem[rd_phys] : '0;
            end
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign level      = level_q;
    assign step_count = step_q;
    assign running    = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign wrapped    = wrapped_q;
`ifdef M1_TRACE_BREAK_EN
    assign bp_hit     = bp_hit_q;
`endif

endmodule

// File: tb/tb_m1_trace_buffer.sv
// tb_m1_trace_buffer: drives DEPTH=8 and DEPTH=64 instances with shared stimulus.
// A queue-based reference model predicts status; a scoreboard checks readback.
module tb_m1_trace_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        m1_strobe;
    logic [15:0] pc;
    logic [63:0] probe;
    logic        arm;
    logic        mode;
    logic [15:0] stop_limit;
    logic        rd_en;
    logic [5:0]  rd_idx;
`ifdef M1_TRACE_BREAK_EN
    logic        bp_en;
    logic [15:0] bp_addr;
    logic        bp_hit8, bp_hit64;
`endif

    logic [79:0] rd_data8, rd_data64;
    logic        rd_valid8, rd_valid64;
    logic [3:0]  level8;
    logic [6:0]  level64;
    logic [15:0] step8, step64;
    logic        running8, running64, done8, done64, wrapped8, wrapped64;

    always #5 clk = ~clk;

    m1_trace_buffer #(.DEPTH(8)) u8 (
        .clk(clk), .rst(rst), .m1_strobe(m1_strobe), .pc(pc), .probe(probe),
        .arm(arm), .mode(mode), .stop_limit(stop_limit),
`ifdef M1_TRACE_BREAK_EN
        .bp_en(bp_en), .bp_addr(bp_addr), .bp_hit(bp_hit8),
`endif
        .rd_en(rd_en), .rd_idx(rd_idx[2:0]), .rd_data(rd_data8),
        .rd_valid(rd_valid8), .level(level8), .step_count(step8),
        .running(running8), .done(done8), .wrapped(wrapped8)
    );

    m1_trace_buffer #(.DEPTH(64)) u64 (
        .clk(clk), .rst(rst), .m1_strobe(m1_strobe), .pc(pc), .probe(probe),
        .arm(arm), .mode(mode), .stop_limit(stop_limit),
`ifdef M1_TRACE_BREAK_EN
        .bp_en(bp_en), .bp_addr(bp_addr), .bp_hit(bp_hit64),
`endif
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data64),
        .rd_valid(rd_valid64), .level(level64), .step_count(step64),
        .running(running64), .done(done64), .wrapped(wrapped64)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc_n = 0;

    typedef struct {
        logic [79:0] d;
        int          due;
    } exp_t;

    exp_t sb8[$];
    exp_t sb64[$];

    // Reference model: trace as an oldest-first list, 0=idle 1=run 2=done
    logic [79:0] mq8[$];
    logic [79:0] mq64[$];
    int mst[2];
    int mstep[2];
    int mmode[2];
    int mlimit[2];
    int mwrap[2];
    int mbp[2];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    function automatic int msize(input int k);
        return (k == 0) ? mq8.size() : mq64.size();
    endfunction

    function automatic logic [79:0] mget(input int k, input int i);
        return (k == 0) ? mq8[i] : mq64[i];
    endfunction

    task automatic mclear(input int k);
        if (k == 0) mq8.delete();
        else mq64.delete();
    endtask

    task automatic mpush(input int k, input logic [79:0] v);
        if (k == 0) mq8.push_back(v);
        else mq64.push_back(v);
    endtask

    task automatic mdrop(input int k);
        if (k == 0) void'(mq8.pop_front());
        else void'(mq64.pop_front());
    endtask

    // Apply the current inputs to the model for one clock edge
    task automatic meval(input int k);
        int   d;
        int   idx;
        bit   stp;
        exp_t e;
        d   = (k == 0) ? 8 : 64;
        idx = (k == 0) ? int'(rd_idx[2:0]) : int'(rd_idx);
        if (!rst) begin
            mst[k] = 0;
            mclear(k);
            mstep[k] = 0;
            mwrap[k] = 0;
            mbp[k] = 0;
            return;
        end
        if (rd_en) begin
            e.d   = (idx < msize(k)) ? mget(k, idx) : 80'h0;
            e.due = cyc_n + 1;
            if (k == 0) sb8.push_back(e);
            else sb64.push_back(e);
        end
        if (arm) begin
            mst[k] = 1;
            mclear(k);
            mstep[k] = 0;
            mwrap[k] = 0;
            mbp[k] = 0;
            mmode[k] = int'(mode);
            mlimit[k] = int'(stop_limit);
        end else if (mst[k] == 1 && m1_strobe) begin
            if (msize(k) == d) begin
                mdrop(k);
                mwrap[k] = 1;
            end
            mpush(k, {pc, probe});
            if (mstep[k] < 65535) mstep[k]++;
            stp = (mlimit[k] != 0 && mstep[k] == mlimit[k]) ||
                  (mmode[k] == 0 && msize(k) == d);
`ifdef M1_TRACE_BREAK_EN
            if (bp_en && pc == bp_addr) begin
                mbp[k] = 1;
                stp = 1'b1;
            end
`endif
            if (stp) mst[k] = 2;
        end
    endtask

    // One clock: predict, advance, then compare status against the model
    task automatic cyc();
        meval(0);
        meval(1);
        @(posedge clk);
        #1;
        chk("level8", 32'(level8), 32'(msize(0)));
        chk("level64", 32'(level64), 32'(msize(1)));
        chk("step8", 32'(step8), 32'(mstep[0]));
        chk("step64", 32'(step64), 32'(mstep[1]));
        chk("running8", 32'(running8), 32'(mst[0] == 1));
        chk("running64", 32'(running64), 32'(mst[1] == 1));
        chk("done8", 32'(done8), 32'(mst[0] == 2));
        chk("done64", 32'(done64), 32'(mst[1] == 2));
        chk("wrapped8", 32'(wrapped8), 32'(mwrap[0]));
        chk("wrapped64", 32'(wrapped64), 32'(mwrap[1]));
`ifdef M1_TRACE_BREAK_EN
        chk("bp_hit8", 32'(bp_hit8), 32'(mbp[0]));
        chk("bp_hit64", 32'(bp_hit64), 32'(mbp[1]));
`endif
    endtask

    // Readback monitors: pop one prediction per rd_valid, check data and latency
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rd_valid8 === 1'b1) begin
            n_chk++;
            if (sb8.size() == 0) begin
                n_fail++;
                $display("FAIL rd8_spurious: rd_valid with no pending read");
            end else begin
                e = sb8.pop_front();
                if (rd_data8 !== e.d || e.due != cyc_n) begin
                    n_fail++;
                    $display("FAIL rd8: got %h at cycle %0d expected %h at cycle %0d",
                             rd_data8, cyc_n, e.d, e.due);
                end
            end
        end else if (sb8.size() > 0 && sb8[0].due <= cyc_n) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd8_missing: rd_valid 0 expected 1 at cycle %0d", cyc_n);
            void'(sb8.pop_front());
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rd_valid64 === 1'b1) begin
            n_chk++;
            if (sb64.size() == 0) begin
                n_fail++;
                $display("FAIL rd64_spurious: rd_valid with no pending read");
            end else begin
                e = sb64.pop_front();
                if (rd_data64 !== e.d || e.due != cyc_n) begin
                    n_fail++;
                    $display("FAIL rd64: got %h at cycle %0d expected %h at cycle %0d",
                             rd_data64, cyc_n, e.d, e.due);
                end
            end
        end else if (sb64.size() > 0 && sb64[0].due <= cyc_n) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd64_missing: rd_valid 0 expected 1 at cycle %0d", cyc_n);
            void'(sb64.pop_front());
        end
    end

    task automatic strobe(input logic [15:0] p);
        m1_strobe = 1'b1;
        pc = p;
        probe = {$urandom(), $urandom()};
        cyc();
        m1_strobe = 1'b0;
    endtask

    task automatic do_arm(input logic m, input logic [15:0] lim);
        arm = 1'b1;
        mode = m;
        stop_limit = lim;
        cyc();
        arm = 1'b0;
    endtask

    task automatic rd(input logic [5:0] i);
        rd_en = 1'b1;
        rd_idx = i;
        cyc();
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        m1_strobe = 1'b0;
        pc = '0;
        probe = '0;
        arm = 1'b0;
        mode = 1'b0;
        stop_limit = '0;
        rd_en = 1'b0;
        rd_idx = '0;
`ifdef M1_TRACE_BREAK_EN
        bp_en = 1'b0;
        bp_addr = '0;
`endif

        // Reset, then strobes without arm are ignored
        repeat (3) cyc();
        rst = 1'b1;
        chk("rst_rd_data8", 32'(rd_data8[31:0]), 32'h0);
        chk("rst_rd_valid8", 32'(rd_valid8), 32'h0);
        for (int i = 0; i < 5; i++) strobe(16'(i));
        chk("idle_level8", 32'(level8), 32'h0);

        // One-shot fill
        do_arm(1'b0, 16'd0);
        for (int i = 0; i < 10; i++) strobe(16'(i));
        chk("oneshot_done8", 32'(done8), 32'h1);
        chk("oneshot_level8", 32'(level8), 32'h8);
        chk("oneshot_step8", 32'(step8), 32'h8);
        rd(6'd0);
        chk("oneshot_idx0", 32'(rd_data8[79:64]), 32'h0000);
        rd(6'd7);
        chk("oneshot_idx7", 32'(rd_data8[79:64]), 32'h0007);
        for (int i = 0; i < 8; i++) rd(6'(i));

        // Circular wrap
        do_arm(1'b1, 16'd0);
        for (int i = 0; i < 11; i++) strobe(16'h0100 + 16'(i));
        chk("circ_wrapped8", 32'(wrapped8), 32'h1);
        chk("circ_running8", 32'(running8), 32'h1);
        rd(6'd0);
        chk("circ_idx0", 32'(rd_data8[79:64]), 32'h0103);
        rd(6'd7);
        chk("circ_idx7", 32'(rd_data8[79:64]), 32'h010A);
        for (int i = 0; i < 12; i++) rd(6'(i));

        // Step limit
        do_arm(1'b1, 16'd100);
        for (int i = 1; i <= 150; i++) strobe(16'h2000 + 16'(i));
        chk("limit_done64", 32'(done64), 32'h1);
        chk("limit_step64", 32'(step64), 32'd100);
        rd(6'd63);
        chk("limit_idx63", 32'(rd_data64[79:64]), 32'h2064);
        rd(6'd0);
        chk("limit_idx0", 32'(rd_data64[79:64]), 32'h2025);

        // Arm coincident with a strobe discards the strobe
        arm = 1'b1;
        mode = 1'b0;
        stop_limit = '0;
        m1_strobe = 1'b1;
        pc = 16'h3000;
        cyc();
        arm = 1'b0;
        m1_strobe = 1'b0;
        chk("arm_strobe_level8", 32'(level8), 32'h0);
        for (int i = 0; i < 3; i++) strobe(16'h3001 + 16'(i));
        rd(6'd5);
        chk("rd_beyond_level", 32'(rd_data8[31:0]), 32'h0);
        chk("rd_beyond_valid", 32'(rd_valid8), 32'h1);

        // Reset mid-run
        m1_strobe = 1'b1;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        m1_strobe = 1'b0;
        chk("midrst_running8", 32'(running8), 32'h0);
        chk("midrst_level8", 32'(level8), 32'h0);

`ifdef M1_TRACE_BREAK_EN
        bp_en = 1'b1;
        bp_addr = 16'h18DC;
        do_arm(1'b0, 16'd0);
        strobe(16'h18D9);
        strobe(16'h18DA);
        strobe(16'h18DC);
        strobe(16'h18DF);
        chk("bp_done8", 32'(done8), 32'h1);
        chk("bp_hit8_dir", 32'(bp_hit8), 32'h1);
        chk("bp_level8", 32'(level8), 32'h3);
        rd(6'd2);
        chk("bp_idx2", 32'(rd_data8[79:64]), 32'h18DC);
        bp_en = 1'b0;
`endif

        // Randomized traffic, including reads coincident with captures
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) != 0);
            arm = ($urandom_range(0, 79) == 0);
            mode = 1'($urandom());
            stop_limit = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 90));
            m1_strobe = 1'($urandom());
            pc = 16'($urandom());
            probe = {$urandom(), $urandom()};
            rd_en = ($urandom_range(0, 2) == 0);
            rd_idx = 6'($urandom());
`ifdef M1_TRACE_BREAK_EN
            bp_en = ($urandom_range(0, 9) == 0);
            bp_addr = {8'h00, pc[7:0]};
            pc = ($urandom_range(0, 3) == 0) ? {8'h00, pc[7:0]} : pc;
`endif
            cyc();
        end
        rst = 1'b1;
        arm = 1'b0;
        m1_strobe = 1'b0;
        rd_en = 1'b0;
        repeat (3) cyc();
        chk("sb8_drained", 32'(sb8.size()), 32'h0);
        chk("sb64_drained", 32'(sb64.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
